// File: rtl/mul_product_serializer_if.sv
// Handshake bundle between the multiplier, the product serializer and the
// ALU result bus. The slave view belongs to the serializer.
interface mul_product_serializer_if #(
  parameter int DEPTH = 2
) ();
  logic                      in_valid;
  logic                      in_ready;
  logic [63:0]               in_prod;
  logic                      out_valid;
  logic                      out_ready;
  logic [31:0]               out_data;
  logic                      out_hi;
  logic                      out_ovf;
  logic [$clog2(DEPTH):0]    level;

  modport slave (
    input  in_valid, in_prod, out_ready,
    output in_ready, out_valid, out_data, out_hi, out_ovf, level
  );

  modport master (
    output in_valid, in_prod, out_ready,
    input  in_ready, out_valid, out_data, out_hi, out_ovf, level
  );
endinterface

// File: rtl/mul_product_serializer.sv
// Buffers 64-bit multiplier products in a small FIFO and emits each one as
// two 32-bit beats on the result bus: LO word first, then HI word. The LO
// beat carries an overflow flag when the HI word is nonzero.
module mul_product_serializer #(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  mul_product_serializer_if.slave  bus
);
  localparam int            AW   = $clog2(DEPTH);
  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);

  typedef enum logic {S_LO, S_HI} state_t;

  state_t                  state, state_nxt;
  logic [DEPTH-1:0][63:0]  mem;
  logic [AW-1:0]           rptr, wptr;
  logic [AW:0]             level;
  logic [63:0]             head;
  logic                    push, pop, xfer, vld, rdy;

  // Ready depends only on occupancy, never on out_ready.
  assign rdy  = !rst && (level < FULL);
  assign vld  = !rst && (level != '0);
  assign push = bus.in_valid && rdy;
  assign xfer = vld && bus.out_ready;
  assign pop  = xfer && (state == S_HI);
  assign head = mem[rptr];

  assign bus.in_ready  = rdy;
  assign bus.out_valid = vld;
  assign bus.level     = level;

  // Product storage; contents need no reset since level qualifies them.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= bus.in_prod;
  end

  // Pointer and occupancy bookkeeping; a push and a pop together cancel.
  always_ff @(posedge clk) begin
    if (rst) begin
      rptr  <= '0;
      wptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Beat-select state register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_LO;
    else     state <= state_nxt;
  end

  // Advance the beat on each accepted word; drive the word mux and flags.
  always_comb begin
    state_nxt    = state;
    bus.out_data = '0;
    bus.out_hi   = 1'b0;
    bus.out_ovf  = 1'b0;
    if (xfer) state_nxt = (state == S_LO) ? S_HI : S_LO;
    if (vld) begin
      if (state == S_HI) begin
        bus.out_data = head[63:32];
        bus.out_hi   = 1'b1;
      end else begin
        bus.out_data = head[31:0];
        bus.out_ovf  = |head[63:32];
      end
    end
  end
endmodule

// File: tb/tb_mul_product_serializer.sv
// Randomized and directed bench for the product serializer. The reference
// keeps a queue of stored products plus a flag for "LO already sent".
module tb_mul_product_serializer;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [63:0] model[$];
  logic        beat = 1'b0;
  logic        last_push;

  mul_product_serializer_if #(.DEPTH(DEPTH)) bus ();

  mul_product_serializer #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive inputs, check outputs against the queue model, then
  // let the edge happen and advance the model.
  task automatic cycle(input logic r, input logic iv, input logic [63:0] p, input logic ordy);
    int          lvl;
    logic        e_rdy, e_vld, e_hi, e_ovf, push, xfer;
    logic [63:0] hd;
    logic [31:0] e_dat;
    @(negedge clk);
    rst = r;
    bus.in_valid  = iv;
    bus.in_prod   = p;
    bus.out_ready = ordy;
    #1;
    lvl   = model.size();
    e_rdy = !r && (lvl < DEPTH);
    e_vld = !r && (lvl != 0);
    hd    = (lvl != 0) ? model[0] : 64'h0;
    e_dat = !e_vld ? 32'h0 : (beat ? hd[63:32] : hd[31:0]);
    e_hi  = e_vld && beat;
    e_ovf = e_vld && !beat && (hd[63:32] != 32'h0);
    chk("in_ready",  64'(bus.in_ready),  64'(e_rdy));
    chk("out_valid", 64'(bus.out_valid), 64'(e_vld));
    chk("out_data",  64'(bus.out_data),  64'(e_dat));
    chk("out_hi",    64'(bus.out_hi),    64'(e_hi));
    chk("out_ovf",   64'(bus.out_ovf),   64'(e_ovf));
    if (!r) chk("level", 64'(bus.level), 64'(lvl));
    push = iv && e_rdy;
    xfer = e_vld && ordy;
    @(posedge clk);
    last_push = push;
    if (r) begin
      model.delete();
      beat = 1'b0;
    end else begin
      if (xfer) begin
        if (beat) begin
          void'(model.pop_front());
          beat = 1'b0;
        end else begin
          beat = 1'b1;
        end
      end
      if (push) model.push_back(p);
    end
  endtask

  function automatic logic [63:0] rnd_prod();
    logic [63:0] v;
    v = {$urandom(), $urandom()};
    if ($urandom_range(0, 1) == 0) v[63:32] = 32'h0;
    return v;
  endfunction

  initial begin
    logic [63:0] prods[8];
    int          idx;
    int          guard;
    bus.in_valid  = 1'b0;
    bus.in_prod   = 64'h0;
    bus.out_ready = 1'b0;

    // Reset and idle reset-state check.
    cycle(1, 0, 64'h0, 0);
    cycle(1, 1, 64'h0, 1);
    cycle(0, 0, 64'h0, 0);

    // Basic beat order with overflow.
    cycle(0, 1, 64'hFFFFFFFE_00000001, 1);
    repeat (3) cycle(0, 0, 64'h0, 1);

    // No overflow.
    cycle(0, 1, 64'h00000000_00001234, 1);
    repeat (3) cycle(0, 0, 64'h0, 1);

    // Backpressure: third product refused until the first pop.
    cycle(0, 1, 64'h11111111_AAAAAAAA, 0);
    cycle(0, 1, 64'h22222222_BBBBBBBB, 0);
    cycle(0, 1, 64'h00000000_CCCCCCCC, 0);
    cycle(0, 1, 64'h00000000_CCCCCCCC, 0);
    last_push = 1'b0;
    guard = 0;
    while (!last_push && guard < 10) begin
      cycle(0, 1, 64'h00000000_CCCCCCCC, 1);
      guard++;
    end
    chk("third_accepted", 64'(last_push), 64'h1);
    repeat (8) cycle(0, 0, 64'h0, 1);

    // Stall during the HI beat.
    cycle(0, 1, 64'hDEADBEEF_01234567, 0);
    cycle(0, 0, 64'h0, 1);
    repeat (5) cycle(0, 0, 64'h0, 0);
    repeat (2) cycle(0, 0, 64'h0, 1);

    // Back-to-back stream of 8 products through pointer wrap.
    foreach (prods[i]) prods[i] = rnd_prod();
    idx = 0;
    guard = 0;
    while (idx < 8 && guard < 40) begin
      cycle(0, 1, prods[idx], 1);
      if (last_push) idx++;
      guard++;
    end
    chk("stream_accepted", 64'(idx), 64'd8);
    repeat (20) cycle(0, 0, 64'h0, 1);

    // Reset while in the HI beat with a full FIFO.
    cycle(0, 1, 64'h99999999_12121212, 0);
    cycle(0, 1, 64'h88888888_34343434, 0);
    cycle(0, 0, 64'h0, 1);
    cycle(1, 0, 64'h0, 0);
    cycle(0, 1, 64'h00000005_00000006, 1);
    repeat (3) cycle(0, 0, 64'h0, 1);

    // Random traffic with occasional reset.
    repeat (600) begin
      cycle(($urandom_range(0, 60) == 0), ($urandom_range(0, 3) != 0), rnd_prod(),
            ($urandom_range(0, 3) != 0));
    end
    repeat (10) cycle(0, 0, 64'h0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mul_product_serializer.md
# mul_product_serializer

Output stage placed directly downstream of the 32x32 unsigned array multiplier. It accepts the multiplier's 64-bit product through a valid/ready handshake and buffers it in a small FIFO. It then delivers the product on the 32-bit ALU result bus as two beats, LO word first and then HI word. An overflow flag marks products that do not fit in 32 bits.

## Interface
Parameters:
- DEPTH, 2: FIFO entries, in 64-bit products. Must be a power of two and at least 2.

Ports:
- clk  in  1  Single clock; all state updates on the rising edge.
- rst  in  1  Synchronous reset, active-high.
- in_valid  in  1  in_prod holds a valid product.
- in_ready  out  1  FIFO can accept a product this cycle.
- in_prod  in  64  Unsigned product from the multiplier.
- out_valid  out  1  out_data holds a valid word.
- out_ready  in  1  Consumer accepts the word this cycle.
- out_data  out  32  Current word: LO beat = in_prod[31:0], HI beat = in_prod[63:32].
- out_hi  out  1  0 on the LO beat, 1 on the HI beat.
- out_ovf  out  1  On the LO beat: 1 if the HI word of the head entry is nonzero. 0 on the HI beat.
- level  out  $clog2(DEPTH)+1  Number of products held, including one partly sent.

## Operation
- Input transfer: in_valid && in_ready at a rising edge. The product is written at the write pointer, then wptr++ and level++.
- in_ready = !rst && (level < DEPTH).
  - in_ready does not depend on out_ready, so there is no combinational in-to-out path.
- FIFO: circular buffer with rptr and wptr, each $clog2(DEPTH) bits. Pointers wrap from DEPTH-1 to 0.
- Serializer FSM, 2 states:
  - S_LO (reset state): present LO of the head entry. On output transfer, go to S_HI.
  - S_HI: present HI of the head entry. On output transfer, pop the entry (rptr++, level--) and go to S_LO.
- out_valid = (level != 0).
  - When out_valid is 0: out_data = 0, out_hi = 0, out_ovf = 0.
- Output transfer: out_valid && out_ready at a rising edge.
  - With out_valid = 0 the FSM holds its state.
  - With out_ready = 0 all outputs hold stable.
- Simultaneous push and pop (HI beat accepted while a product is pushed): both take effect and level is unchanged.
  - When full, in_ready = 0, so a push is impossible even while a pop occurs in the same cycle.
- Words pass through unmodified; no arithmetic is done on them. out_ovf = |head[63:32].

## Timing
- Reset, sampled at a rising edge with rst = 1: rptr = 0, wptr = 0, level = 0, state = S_LO. Stored FIFO data is don't-care.
- While rst is high: in_ready = 0, out_valid = 0, out_data = 0, out_hi = 0, out_ovf = 0.
- Reset mid-operation (FSM in S_HI, FIFO non-empty) discards all entries. No HI beat is emitted after reset.
- Latency: a product accepted at edge N gives out_valid = 1 with its LO word after edge N (visible in cycle N+1). There is no same-cycle bypass.
- Throughput: one word per cycle with out_ready held high, so one product every 2 cycles.
  - A continuous input stream fills the FIFO, and in_ready then toggles to sustain 1 product per 2 cycles.
- A full FIFO needs DEPTH*2 output beats to drain.

## Test plan
- Basic beat order: push 0xFFFFFFFE00000001 with out_ready = 1.
  - Cycle after accept: out_data = 0x00000001, out_hi = 0, out_ovf = 1.
  - Next cycle: out_data = 0xFFFFFFFE, out_hi = 1, out_ovf = 0.
  - Then out_valid = 0 and level = 0.
- No overflow: push 0x0000000000001234.
  - LO beat: out_data = 0x00001234, out_ovf = 0.
  - HI beat: out_data = 0x00000000.
- Backpressure and full: with out_ready = 0, push 3 products (DEPTH = 2).
  - The first two are accepted, level = 2, and in_ready = 0 on the third.
  - Raise out_ready: 4 beats arrive in FIFO order. The third product is accepted in the cycle after the first pop.
- Stall stability: drop out_ready during the HI beat for 5 cycles. out_data, out_hi and out_valid hold unchanged, and level stays constant.
- Simultaneous push/pop and wrap: stream 8 products back-to-back with out_ready = 1.
  - All 16 words arrive in order.
  - Pointers wrap without loss or duplication.
  - level never exceeds 2.
- Reset mid-operation: assert rst for 1 cycle while in S_HI with level = 2.
  - Next cycle: out_valid = 0, level = 0, in_ready = 1.
  - A new product's LO beat comes out first.
